desynk_target_model: RTL
========================

Name: desynk_target_model

Overview:
- Synthesizable stand-in for a glitch target, driven by the desynk glitcher's target-side outputs and answering on its ready/success inputs.
- Lets the team close the loop on-board, wiring glitcher outputs to model inputs on a second PMOD, without real silicon.
- Runs on the fabric clock, oversamples the incoming target clock and power, reset and throttle lines, and models boot, a vulnerable check window, and crash-on-glitch.
- Reports "success" when a shortened clock period lands inside the check window.

Parameters:
- BOOT_EDGES, 16: target-clock rising edges needed to finish boot.
- CHECK_EDGES, 32: non-throttled target-clock rising edges in the vulnerable check window.
- MIN_PERIOD, 8: a target-clock period shorter than this many fabric cycles counts as a glitch; legal range 2..2^COUNT_W-1.
- COUNT_W, 8: width of the period counter.

Ports:
- clk, input, 1: fabric clock.
- io_reset, input, 1: synchronous, active-high reset.
- io_target_clk, input, 1: target clock from the glitcher (asynchronous to clk).
- io_target_reset, input, 1: target reset, active-high (async, synchronized internally).
- io_target_power, input, 1: target power enable, high = powered (async).
- io_target_throttle, input, 1: target throttle, high = stall check progress (async).
- io_target_ready, output, 1: target booted and alive.
- io_target_success, output, 1: check window was glitched.
- glitch_count, output, 8: saturating count of glitch edges since leaving OFF.
- state, output, 2: debug state code (OFF=0, BOOT=1, CHECK=2, DONE/HUNG=3).

Behaviour:
- Reset (io_reset high at a clk edge):
  - state=OFF; io_target_ready=0; io_target_success=0; glitch_count=0.
  - All synchronizer flops cleared; period counter preset to all-ones.
- Synchronization:
  - Each async input passes through 2 flops.
  - io_target_clk gets a 3rd flop. The edge pulse is sync2 & ~sync3, so a rising edge is seen 3 clk after the pin rises.
- Period counter:
  - Saturates at 2^COUNT_W-1.
  - Cleared to 0 in an edge cycle; otherwise increments.
  - On an edge, the measured period is cnt+1.
  - glitch_edge = edge and (cnt+1 < MIN_PERIOD).
  - Preset to all-ones while in OFF, so the first edge after power-up is never a glitch.
- Off condition: power_s==0 or reset_s==1. It overrides everything, is evaluated every cycle, and forces OFF next cycle with ready=0, success=0, glitch_count=0.
- State machine, registered, one transition per clk:
  - OFF -> BOOT when the off condition is false; edge counter=0.
  - BOOT:
    - glitch_edge -> HUNG.
    - else edge -> counter+1.
    - The edge making counter==BOOT_EDGES -> CHECK; counter=0; io_target_ready=1 on that same clk edge.
  - CHECK (ready=1):
    - glitch_edge -> DONE with success=1. This applies regardless of throttle.
    - Non-glitch edge with throttle_s==0 -> counter+1.
    - Edges while throttled do not advance the counter.
    - Counter reaching CHECK_EDGES -> DONE with success=0.
  - DONE: ready=1; success holds. Further glitches only increment glitch_count.
  - HUNG: ready=0, success=0; waits for the off condition. The state output reads 3 for both DONE and HUNG; ready distinguishes them.
- Simultaneous events:
  - The off condition beats any edge in the same cycle.
  - A glitch_edge on the last CHECK edge gives success=1.
- glitch_count increments on every glitch_edge in BOOT, CHECK, DONE or HUNG, and saturates at 255.
- io_reset mid-operation returns to OFF in 1 cycle. The model then re-boots only after power/reset inputs permit, 2 synchronizer cycles later.

Test Plan:
1. Power=1, reset=0, target clk period 20 clk, no glitch. Ready rises 3–4 clk after the 16th edge. After 32 more edges, state=3, ready=1, success=0, glitch_count=0.
2. Same as test 1, plus one 4-clk period inserted at CHECK edge 10. Success=1 on that edge, ready stays 1, glitch_count=1.
3. 4-clk period at BOOT edge 5. State=3, ready=0, success=0, glitch_count=1. Pulse power low, then high: re-boots cleanly, glitch_count=0.
4. In CHECK, throttle=1 for 40 edges, then 0. Still in CHECK after the 40 throttled edges; DONE only after 32 unthrottled edges. A glitch while throttled still sets success=1.
5. Period exactly MIN_PERIOD=8 clk gives no glitch; 7 clk gives a glitch. The first edge after power-on is never counted as a glitch.
6. Assert io_reset during CHECK; all outputs are 0 the next cycle. Assert io_target_reset during DONE; ready and success drop within 3 clk.

Source files
------------

// File: rtl/desynk_target_model.sv
// Fabric-clocked stand-in for a glitch target: oversamples the glitcher's target-side
// lines, models boot / vulnerable check window / crash, and flags glitch success.
module desynk_target_model #(
    parameter int BOOT_EDGES  = 16,
    parameter int CHECK_EDGES = 32,
    parameter int MIN_PERIOD  = 8,
    parameter int COUNT_W     = 8
) (
    input  logic       clk,
    input  logic       io_reset,
    input  logic       io_target_clk,
    input  logic       io_target_reset,
    input  logic       io_target_power,
    input  logic       io_target_throttle,
    output logic       io_target_ready,
    output logic       io_target_success,
    output logic [7:0] glitch_count,
    output logic [1:0] state
);

    localparam int EDGE_MAX = (BOOT_EDGES > CHECK_EDGES) ? BOOT_EDGES : CHECK_EDGES;
    localparam int EDGE_W   = $clog2(EDGE_MAX + 1);

    localparam logic [COUNT_W:0]  MIN_P      = (COUNT_W+1)'(MIN_PERIOD);
    localparam logic [EDGE_W-1:0] BOOT_LAST  = EDGE_W'(BOOT_EDGES);
    localparam logic [EDGE_W-1:0] CHECK_LAST = EDGE_W'(CHECK_EDGES);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_BOOT  = 3'd1,
        S_CHECK = 3'd2,
        S_DONE  = 3'd3,
        S_HUNG  = 3'd4
    } state_e;

    logic [2:0]         tclk_q;
    logic [1:0]         power_q;
    logic [1:0]         treset_q;
    logic [1:0]         throttle_q;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [EDGE_W-1:0]  ecnt_q, ecnt_d, ecnt_inc;
    logic [7:0]         gcnt_q, gcnt_d;
    logic               success_q, success_d;
    state_e             state_q, state_d;

    logic               edge_pulse;
    logic               glitch_edge;
    logic               off_cond;
    logic [COUNT_W:0]   period;

    always_ff @(posedge clk) begin
        if (io_reset) begin
            tclk_q     <= '0;
            power_q    <= '0;
            treset_q   <= '0;
            throttle_q <= '0;
        end else begin
            tclk_q     <= {tclk_q[1:0], io_target_clk};
            power_q    <= {power_q[0], io_target_power};
            treset_q   <= {treset_q[0], io_target_reset};
            throttle_q <= {throttle_q[0], io_target_throttle};
        end
    end

    // Period is measured edge-to-edge; a saturated counter can never look like a glitch.
    assign edge_pulse  = tclk_q[1] & ~tclk_q[2];
    assign period      = {1'b0, cnt_q} + {{COUNT_W{1'b0}}, 1'b1};
    assign glitch_edge = edge_pulse && (period < MIN_P);
    assign off_cond    = ~power_q[1] | treset_q[1];
    assign ecnt_inc    = ecnt_q + EDGE_W'(1);

    always_comb begin
        cnt_d = cnt_q;
        if (off_cond || (state_q == S_OFF)) begin
            cnt_d = '1;
        end else if (edge_pulse) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + COUNT_W'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        ecnt_d    = ecnt_q;
        success_d = success_q;
        gcnt_d    = gcnt_q;
        if (glitch_edge && (state_q != S_OFF) && (gcnt_q != 8'hFF)) begin
            gcnt_d = gcnt_q + 8'd1;
        end
        unique case (state_q)
            S_OFF: begin
                state_d   = S_BOOT;
                ecnt_d    = '0;
                success_d = 1'b0;
                gcnt_d    = '0;
            end
            S_BOOT: begin
                if (glitch_edge) begin
                    state_d = S_HUNG;
                end else if (edge_pulse) begin
                    if (ecnt_inc == BOOT_LAST) begin
                        state_d = S_CHECK;
                        ecnt_d  = '0;
                    end else begin
                        ecnt_d = ecnt_inc;
                    end
                end
            end
            S_CHECK: begin
                // A glitch wins even when throttled or on the final window edge.
                if (glitch_edge) begin
                    state_d   = S_DONE;
                    success_d = 1'b1;
                end else if (edge_pulse && !throttle_q[1]) begin
                    if (ecnt_inc == CHECK_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        ecnt_d = ecnt_inc;
                    end
                end
            end
            S_DONE, S_HUNG: begin
                state_d = state_q;
            end
            default: begin
                state_d = S_OFF;
            end
        endcase
        if (off_cond) begin
            state_d   = S_OFF;
            ecnt_d    = '0;
            success_d = 1'b0;
            gcnt_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (io_reset) begin
            state_q   <= S_OFF;
            cnt_q     <= '1;
            ecnt_q    <= '0;
            gcnt_q    <= '0;
            success_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ecnt_q    <= ecnt_d;
            gcnt_q    <= gcnt_d;
            success_q <= success_d;
        end
    end

    assign io_target_ready   = (state_q == S_CHECK) || (state_q == S_DONE);
    assign io_target_success = success_q;
    assign glitch_count      = gcnt_q;

    always_comb begin
        unique case (state_q)
            S_OFF:   state = 2'd0;
            S_BOOT:  state = 2'd1;
            S_CHECK: state = 2'd2;
            default: state = 2'd3;
        endcase
    end

endmodule
